ex_mem_pipe: RTL and testbench
==============================

# ex_mem_pipe

Pipeline register between the execute stage and the memory stage of the pipelined processor. It captures the ALU result, store data and memory/writeback control from execute, and presents them to the memory stage. It holds them stable while the memory system reports a stall, so Rd/Wr stay asserted until the cache completes. It also back-pressures the front of the pipe and flags a stuck memory access through a watchdog.

## Interface
- `TIMEOUT`, default 63: maximum consecutive `stall_mem` cycles before fault.

Ports:
- `clk`  in  1  processor clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `ex_valid`  in  1  execute slot holds a real instruction.
- `ex_alu_result`  in  16  address / ALU output.
- `ex_read2_data`  in  16  store data.
- `ex_mem_read`, `ex_mem_write`, `ex_halt`, `ex_reg_write`, `ex_mem_to_reg`  in  1 each  control.
- `ex_write_reg`  in  3  destination register.
- `flush`  in  1  replace the incoming execute instruction with a bubble.
- `stall_mem`  in  1  memory stage busy (from memory stage).
- `mem_valid`, `mem_read`, `mem_write`, `mem_halt`, `mem_reg_write`, `mem_mem_to_reg`  out  1 each  registered control.
- `mem_alu_result`, `mem_read2_data`  out  16  registered data.
- `mem_write_reg`  out  3  registered destination.
- `stall_up`  out  1  freeze ID/EX and earlier stages.
- `err`  out  1  sticky fault flag.

## Operation
- Reset: every output is 0 and the FSM is IDLE.
- Load rule, evaluated each cycle:
  - If `stall_up` is 0, the register loads the execute inputs.
  - If `stall_up` is 0 and `ex_valid` is 0 or `flush` is 1, it loads a bubble: `mem_valid`, `mem_read`, `mem_write`, `mem_halt` and `mem_reg_write` are 0, and data fields are 0.
  - If `stall_up` is 1, all outputs hold.
- `stall_up = stall_mem | halted | (state==FAULT)`. It is combinational from `stall_mem`.
- `flush` has no effect while `stall_up` is 1. The flushed instruction is still in execute and is re-presented.
- Halt: once a valid instruction with `mem_halt=1` is latched, `halted` sets and stays set. Later loads are blocked and outputs hold until reset.
- FSM states are IDLE, BUSY and FAULT.
  - IDLE → BUSY when `stall_mem=1`.
  - BUSY → IDLE when `stall_mem=0` (access done). The register loads the next instruction in that same cycle.
  - BUSY → FAULT when the stall counter reaches `TIMEOUT` while `stall_mem` is still 1.
  - FAULT is absorbing. `err=1` and `stall_up=1` until reset.
- Stall counter:
  - Width is clog2(`TIMEOUT`+1).
  - It clears in IDLE and increments each BUSY cycle that has `stall_mem=1`.
  - It saturates at `TIMEOUT`; it does not wrap.
- A read or write that hits in the same cycle (`stall_mem` never rises) stays in IDLE and advances with 1-cycle occupancy.

## Timing
- Latency is 1 cycle from the execute inputs to the `mem_*` outputs when not stalled.
- `mem_read` and `mem_write` stay asserted continuously from the load cycle through the cycle in which `stall_mem` deasserts. They are never dropped and re-raised mid-access.
- `stall_up` follows `stall_mem` in the same cycle, with no registered delay.
- Reset mid-access: outputs return to 0 the next edge and the FSM returns to IDLE. Any in-flight memory access is abandoned; the memory system is reset by the same `rst`.
- If `rst` and `stall_mem` are high together, reset wins.

## Configuration
- `EX_MEM_ALIGN_CHECK_EN` defined:
  - A valid execute instruction with (`ex_mem_read|ex_mem_write`) and `ex_alu_result[0]=1` is loaded with `mem_read`, `mem_write` and `mem_reg_write` forced to 0.
  - `err` sets and the FSM enters FAULT on the next edge.
- Undefined: no alignment check; addresses pass unchanged. `err` comes only from the watchdog.

## Structure
- A shared package/include `ex_mem_pkg` holds:
  - the FSM state encoding (IDLE=2'b00, BUSY=2'b01, FAULT=2'b10);
  - the data width (16) and register-index width (3);
  - the bubble constant.
- One sub-module, `mem_watchdog`, contains the saturating stall counter and produces a `timeout` pulse.

## Test plan
- Reset, then `ex_valid=1`, `ex_mem_read=1`, `ex_alu_result=16'h0040`, `stall_mem=0` → the next cycle shows `mem_read=1`, `mem_alu_result=16'h0040`, `stall_up=0`.
- Store to 16'h0100 with data 16'hBEEF, `stall_mem=1` for 5 cycles → `mem_write`, address and data hold for all 5 cycles and `stall_up=1`. The new execute instruction loads on the edge after `stall_mem` falls.
- `flush=1` with `stall_up=0` and a valid load in execute → the next cycle shows `mem_valid=0` and `mem_read=0`.
- `flush=1` with `stall_mem=1` → ignored; outputs are unchanged.
- `TIMEOUT=4`, `stall_mem` held high → after 4 BUSY cycles `err=1`. FAULT persists after `stall_mem` drops, and clears only on `rst`.
- `ex_halt=1` with a valid instruction → `mem_halt=1`, `stall_up=1` permanently. Later execute inputs are not loaded.
- With `EX_MEM_ALIGN_CHECK_EN`, a load at 16'h0041 → `mem_read=0`, and `err=1` on the next edge.

Source files
------------

// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg: shared definitions for the EX/MEM pipeline register.
//   - FSM state encoding (StIdle/StBusy/StFault)
//   - data and register-index widths
//   - packed pipeline payload type and its bubble constant
package ex_mem_pkg;

    localparam int unsigned DataW = 16;
    localparam int unsigned RegW  = 3;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StBusy  = 2'b01,
        StFault = 2'b10
    } ex_mem_state_e;

    typedef struct packed {
        logic             valid;
        logic             mem_read;
        logic             mem_write;
        logic             halt;
        logic             reg_write;
        logic             mem_to_reg;
        logic [DataW-1:0] alu_result;
        logic [DataW-1:0] read2_data;
        logic [RegW-1:0]  write_reg;
    } ex_mem_t;

    localparam ex_mem_t Bubble = '0;

endpackage

// File: rtl/mem_watchdog.sv
// mem_watchdog: saturating count of consecutive memory-stall cycles.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   busy       - pipe FSM is waiting on the memory system
//   stall_mem  - memory stage still busy this cycle
//   timeout    - pulse: this cycle's stall brings the count to TIMEOUT
module mem_watchdog #(
    parameter int unsigned TIMEOUT = 63
) (
    input  logic clk,
    input  logic rst,
    input  logic busy,
    input  logic stall_mem,
    output logic timeout
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!busy) begin
            cnt_d = '0;
        end else if (stall_mem && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Fires on the cycle whose stall makes the count reach TIMEOUT.
    assign timeout = busy & stall_mem & (cnt_d == CntMax);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe: EX/MEM pipeline register with memory-stall hold, halt latch
// and stuck-access watchdog.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   ex_*                     - execute-stage instruction fields
//   flush                    - turn the incoming instruction into a bubble
//   stall_mem                - memory stage busy
//   mem_*                    - registered fields presented to memory stage
//   stall_up                 - freeze ID/EX and earlier stages
//   err                      - sticky fault flag
// Optional: define EX_MEM_ALIGN_CHECK_EN to fault on odd-address accesses.
module ex_mem_pipe
    import ex_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 63
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic [DataW-1:0] ex_alu_result,
    input  logic [DataW-1:0] ex_read2_data,
    input  logic             ex_mem_read,
    input  logic             ex_mem_write,
    input  logic             ex_halt,
    input  logic             ex_reg_write,
    input  logic             ex_mem_to_reg,
    input  logic [RegW-1:0]  ex_write_reg,
    input  logic             flush,
    input  logic             stall_mem,
    output logic             mem_valid,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_halt,
    output logic             mem_reg_write,
    output logic             mem_mem_to_reg,
    output logic [DataW-1:0] mem_alu_result,
    output logic [DataW-1:0] mem_read2_data,
    output logic [RegW-1:0]  mem_write_reg,
    output logic             stall_up,
    output logic             err
);

    ex_mem_state_e state_q, state_d;
    ex_mem_t       pipe_q, pipe_d;
    logic          halted_q, halted_d;
    logic          load, take, misaligned, timeout;

    assign stall_up = stall_mem | halted_q | (state_q == StFault);
    assign load     = ~stall_up;
    assign take     = load & ex_valid & ~flush;

`ifdef EX_MEM_ALIGN_CHECK_EN
    assign misaligned = take & (ex_mem_read | ex_mem_write) & ex_alu_result[0];
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        pipe_d = pipe_q;
        if (load) begin
            pipe_d = Bubble;
        end
        if (take) begin
            pipe_d.valid      = 1'b1;
            pipe_d.mem_read   = ex_mem_read;
            pipe_d.mem_write  = ex_mem_write;
            pipe_d.halt       = ex_halt;
            pipe_d.reg_write  = ex_reg_write;
            pipe_d.mem_to_reg = ex_mem_to_reg;
            pipe_d.alu_result = ex_alu_result;
            pipe_d.read2_data = ex_read2_data;
            pipe_d.write_reg  = ex_write_reg;
        end
        // A misaligned access is passed down but never performed.
        if (misaligned) begin
            pipe_d.mem_read  = 1'b0;
            pipe_d.mem_write = 1'b0;
            pipe_d.reg_write = 1'b0;
        end
    end

    assign halted_d = halted_q | (take & ex_halt);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (stall_mem) begin
                    state_d = StBusy;
                end else if (misaligned) begin
                    state_d = StFault;
                end
            end
            StBusy: begin
                if (stall_mem) begin
                    if (timeout) begin
                        state_d = StFault;
                    end
                end else if (misaligned) begin
                    state_d = StFault;
                end else begin
                    state_d = StIdle;
                end
            end
            StFault: state_d = StFault;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            pipe_q   <= Bubble;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pipe_q   <= pipe_d;
            halted_q <= halted_d;
        end
    end

    mem_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_mem_watchdog (
        .clk       (clk),
        .rst       (rst),
        .busy      (state_q == StBusy),
        .stall_mem (stall_mem),
        .timeout   (timeout)
    );

    assign err            = (state_q == StFault);
    assign mem_valid      = pipe_q.valid;
    assign mem_read       = pipe_q.mem_read;
    assign mem_write      = pipe_q.mem_write;
    assign mem_halt       = pipe_q.halt;
    assign mem_reg_write  = pipe_q.reg_write;
    assign mem_mem_to_reg = pipe_q.mem_to_reg;
    assign mem_alu_result = pipe_q.alu_result;
    assign mem_read2_data = pipe_q.read2_data;
    assign mem_write_reg  = pipe_q.write_reg;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Bench for ex_mem_pipe: directed per-cycle vectors push the expected
// outputs into a queue; a negedge monitor pops and compares.
// u_dut uses the default TIMEOUT; u_wd (TIMEOUT=4) exercises the watchdog.
module tb_ex_mem_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rst4, stall4;
    logic        ex_valid, ex_mem_read, ex_mem_write, ex_halt, ex_reg_write, ex_mem_to_reg;
    logic [15:0] ex_alu_result, ex_read2_data;
    logic [2:0]  ex_write_reg;
    logic        flush, stall_mem;

    logic        mem_valid, mem_read, mem_write, mem_halt, mem_reg_write, mem_mem_to_reg;
    logic [15:0] mem_alu_result, mem_read2_data;
    logic [2:0]  mem_write_reg;
    logic        stall_up, err;

    logic        w_valid, w_read, w_write, w_halt, w_reg_write, w_mem_to_reg;
    logic [15:0] w_alu_result, w_read2_data;
    logic [2:0]  w_write_reg;
    logic        stall_up4, err4;

    ex_mem_pipe u_dut (
        .clk (clk), .rst (rst),
        .ex_valid (ex_valid), .ex_alu_result (ex_alu_result),
        .ex_read2_data (ex_read2_data), .ex_mem_read (ex_mem_read),
        .ex_mem_write (ex_mem_write), .ex_halt (ex_halt),
        .ex_reg_write (ex_reg_write), .ex_mem_to_reg (ex_mem_to_reg),
        .ex_write_reg (ex_write_reg), .flush (flush), .stall_mem (stall_mem),
        .mem_valid (mem_valid), .mem_read (mem_read), .mem_write (mem_write),
        .mem_halt (mem_halt), .mem_reg_write (mem_reg_write),
        .mem_mem_to_reg (mem_mem_to_reg), .mem_alu_result (mem_alu_result),
        .mem_read2_data (mem_read2_data), .mem_write_reg (mem_write_reg),
        .stall_up (stall_up), .err (err)
    );

    ex_mem_pipe #(.TIMEOUT (4)) u_wd (
        .clk (clk), .rst (rst4),
        .ex_valid (1'b0), .ex_alu_result (16'h0000),
        .ex_read2_data (16'h0000), .ex_mem_read (1'b0),
        .ex_mem_write (1'b0), .ex_halt (1'b0),
        .ex_reg_write (1'b0), .ex_mem_to_reg (1'b0),
        .ex_write_reg (3'd0), .flush (1'b0), .stall_mem (stall4),
        .mem_valid (w_valid), .mem_read (w_read), .mem_write (w_write),
        .mem_halt (w_halt), .mem_reg_write (w_reg_write),
        .mem_mem_to_reg (w_mem_to_reg), .mem_alu_result (w_alu_result),
        .mem_read2_data (w_read2_data), .mem_write_reg (w_write_reg),
        .stall_up (stall_up4), .err (err4)
    );

    typedef struct {
        string       name;
        logic [44:0] vec;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Monitor: one expected snapshot per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t        e;
            logic [44:0] act;
            e   = q.pop_front();
            act = {mem_valid, mem_read, mem_write, mem_halt, mem_reg_write, mem_mem_to_reg,
                   mem_alu_result, mem_read2_data, mem_write_reg,
                   stall_up, err, stall_up4, err4};
            n_checks++;
            if (act !== e.vec) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.vec);
            end
        end
    end

    task automatic expect_out(input string name,
                              input logic v, input logic rd, input logic wr,
                              input logic hl, input logic rw, input logic m2r,
                              input logic [15:0] alu, input logic [15:0] wd,
                              input logic [2:0] wreg, input logic su, input logic er,
                              input logic su4, input logic er4);
        exp_t e;
        e.name = name;
        e.vec  = {v, rd, wr, hl, rw, m2r, alu, wd, wreg, su, er, su4, er4};
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic clr_ex();
        ex_valid      = 1'b0;
        ex_mem_read   = 1'b0;
        ex_mem_write  = 1'b0;
        ex_halt       = 1'b0;
        ex_reg_write  = 1'b0;
        ex_mem_to_reg = 1'b0;
        ex_alu_result = 16'h0000;
        ex_read2_data = 16'h0000;
        ex_write_reg  = 3'd0;
        flush         = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL sim_time_limit: got timeout expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        clr_ex();
        rst = 1'b1; rst4 = 1'b1; stall_mem = 1'b0; stall4 = 1'b0;
        @(posedge clk);
        #1;
        expect_out("reset", 0,0,0,0,0,0, 16'h0000, 16'h0000, 3'd0, 0,0,0,0);

        // Hit load, one-cycle latency.
        rst = 1'b0; rst4 = 1'b0;
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_alu_result = 16'h0040;
        ex_reg_write = 1'b1; ex_mem_to_reg = 1'b1; ex_write_reg = 3'd3;
        expect_out("load_issue", 0,0,0,0,0,0, 16'h0000, 16'h0000, 3'd0, 0,0,0,0);
        clr_ex();
        expect_out("load_out", 1,1,0,0,1,1, 16'h0040, 16'h0000, 3'd3, 0,0,0,0);

        // Store held through a 5-cycle memory stall.
        ex_valid = 1'b1; ex_mem_write = 1'b1; ex_alu_result = 16'h0100;
        ex_read2_data = 16'hBEEF;
        expect_out("bubble", 0,0,0,0,0,0, 16'h0000, 16'h0000, 3'd0, 0,0,0,0);
        clr_ex();
        ex_valid = 1'b1; ex_reg_write = 1'b1; ex_alu_result = 16'h1234; ex_write_reg = 3'd5;
        stall_mem = 1'b1;
        expect_out("store_s1", 1,0,1,0,0,0, 16'h0100, 16'hBEEF, 3'd0, 1,0,0,0);
        expect_out("store_s2", 1,0,1,0,0,0, 16'h0100, 16'hBEEF, 3'd0, 1,0,0,0);
        flush = 1'b1;
        expect_out("store_s3_flush", 1,0,1,0,0,0, 16'h0100, 16'hBEEF, 3'd0, 1,0,0,0);
        flush = 1'b0;
        expect_out("store_s4", 1,0,1,0,0,0, 16'h0100, 16'hBEEF, 3'd0, 1,0,0,0);
        expect_out("store_s5", 1,0,1,0,0,0, 16'h0100, 16'hBEEF, 3'd0, 1,0,0,0);
        stall_mem = 1'b0;
        expect_out("store_done", 1,0,1,0,0,0, 16'h0100, 16'hBEEF, 3'd0, 0,0,0,0);

        // Flush with the pipe free turns a valid load into a bubble.
        clr_ex();
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_alu_result = 16'h0080;
        ex_reg_write = 1'b1; ex_write_reg = 3'd2; flush = 1'b1;
        expect_out("alu_out", 1,0,0,0,1,0, 16'h1234, 16'h0000, 3'd5, 0,0,0,0);
        clr_ex();
        expect_out("flush_bubble", 0,0,0,0,0,0, 16'h0000, 16'h0000, 3'd0, 0,0,0,0);

        // Watchdog on the TIMEOUT=4 instance: 1 IDLE + 4 BUSY stall cycles.
        stall4 = 1'b1;
        expect_out("wd_s1", 0,0,0,0,0,0, 16'h0000, 16'h0000, 3'd0, 0,0,1,0);
        for (int i = 0; i < 4; i++) begin
            expect_out("wd_busy", 0,0,0,0,0,0, 16'h0000, 16'h0000, 3'd0, 0,0,1,0);
        end
        stall4 = 1'b0;
        expect_out("wd_fault", 0,0,0,0,0,0, 16'h0000, 16'h0000, 3'd0, 0,0,1,1);
        expect_out("wd_persist", 0,0,0,0,0,0, 16'h0000, 16'h0000, 3'd0, 0,0,1,1);
        rst4 = 1'b1;
        expect_out("wd_rst_apply", 0,0,0,0,0,0, 16'h0000, 16'h0000, 3'd0, 0,0,1,1);
        rst4 = 1'b0;
        expect_out("wd_cleared", 0,0,0,0,0,0, 16'h0000, 16'h0000, 3'd0, 0,0,0,0);

        // Odd-address load.
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_alu_result = 16'h0041;
        ex_reg_write = 1'b1; ex_mem_to_reg = 1'b1; ex_write_reg = 3'd4;
        expect_out("align_issue", 0,0,0,0,0,0, 16'h0000, 16'h0000, 3'd0, 0,0,0,0);
        clr_ex();
        rst = 1'b1;
`ifdef EX_MEM_ALIGN_CHECK_EN
        expect_out("align_out", 1,0,0,0,0,1, 16'h0041, 16'h0000, 3'd4, 1,1,0,0);
`else
        expect_out("align_out", 1,1,0,0,1,1, 16'h0041, 16'h0000, 3'd4, 0,0,0,0);
`endif
        rst = 1'b0;
        expect_out("align_reset", 0,0,0,0,0,0, 16'h0000, 16'h0000, 3'd0, 0,0,0,0);

        // Halt latches and freezes the register until reset.
        ex_valid = 1'b1; ex_halt = 1'b1; ex_write_reg = 3'd1;
        expect_out("halt_issue", 0,0,0,0,0,0, 16'h0000, 16'h0000, 3'd0, 0,0,0,0);
        clr_ex();
        ex_valid = 1'b1; ex_reg_write = 1'b1; ex_alu_result = 16'h5555; ex_write_reg = 3'd7;
        expect_out("halt_out", 1,0,0,1,0,0, 16'h0000, 16'h0000, 3'd1, 1,0,0,0);
        ex_alu_result = 16'h7777;
        expect_out("halt_hold", 1,0,0,1,0,0, 16'h0000, 16'h0000, 3'd1, 1,0,0,0);
        rst = 1'b1; stall_mem = 1'b1;
        expect_out("halt_rst_stall", 1,0,0,1,0,0, 16'h0000, 16'h0000, 3'd1, 1,0,0,0);
        rst = 1'b0; stall_mem = 1'b0;
        clr_ex();
        expect_out("halt_cleared", 0,0,0,0,0,0, 16'h0000, 16'h0000, 3'd0, 0,0,0,0);

        // Loads resume after reset.
        ex_valid = 1'b1; ex_reg_write = 1'b1; ex_alu_result = 16'h00AA; ex_write_reg = 3'd6;
        expect_out("resume_issue", 0,0,0,0,0,0, 16'h0000, 16'h0000, 3'd0, 0,0,0,0);
        clr_ex();
        expect_out("resume_out", 1,0,0,0,1,0, 16'h00AA, 16'h0000, 3'd6, 0,0,0,0);

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: got %0d left expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
